// File: rtl/midi_msg_tx.sv
// midi_msg_tx: MIDI channel-message encoder and byte transmitter.
// Optional running status: define MIDI_RUNNING_STATUS_EN.
//
// Ports:
//   reg_clk, reset_reg_n   clock, synchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_type[2:0]          0 note_off, 1 note_on, 2 ctrl,
//                          3 prg_change, 4 pitch, 5..7 illegal
//   req_ch[3:0]            channel (status low nibble)
//   req_d1[6:0], req_d2    data bytes (d2 unused for prg_change)
//   tx_byte/tx_valid       byte stream to the UART
//   tx_ready               UART accepts the byte
//   msg_done               pulse after the last byte handshake
//   req_err                pulse after an illegal request is dropped

module midi_msg_tx #(
   parameter int RS_REFRESH = 8
) (
   input  logic       reg_clk,
   input  logic       reset_reg_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_type,
   input  logic [3:0] req_ch,
   input  logic [6:0] req_d1,
   input  logic [6:0] req_d2,
   output logic [7:0] tx_byte,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       msg_done,
   output logic       req_err
);

   typedef enum logic [1:0] {
      IDLE,
      STATUS,
      DATA1,
      DATA2
   } state_t;

   localparam logic [7:0] RS_LIM = 8'(RS_REFRESH);

   state_t     state_q;
   state_t     state_d;
   logic [7:0] status_q;
   logic [6:0] d1_q;
   logic [6:0] d2_q;
   logic       prg_q;
   logic       done_q;
   logic       done_d;
   logic       err_q;

   logic       accept;
   logic       legal;
   logic       skip;
   logic [3:0] nib;
   logic [7:0] status_new;

   // Gated by reset so nothing is offered while reset is held.
   assign req_ready = reset_reg_n && (state_q == IDLE);
   assign accept    = req_valid && req_ready;
   assign msg_done  = done_q;
   assign req_err   = err_q;

   always_comb begin
      nib   = 4'h0;
      legal = 1'b1;
      unique case (req_type)
         3'd0:    nib = 4'h8;
         3'd1:    nib = 4'h9;
         3'd2:    nib = 4'hB;
         3'd3:    nib = 4'hC;
         3'd4:    nib = 4'hE;
         default: legal = 1'b0;
      endcase
   end

   assign status_new = {nib, req_ch};

`ifdef MIDI_RUNNING_STATUS_EN
   logic [7:0] last_status;
   logic       ls_valid;
   logic [7:0] rs_cnt;

   assign skip = ls_valid
              && (status_new == last_status)
              && (rs_cnt < RS_LIM);

   // Cache is updated at accept time, so an
   // abandoned message still counts until reset.
   always_ff @(posedge reg_clk) begin
      if (!reset_reg_n) begin
         last_status <= 8'h00;
         ls_valid    <= 1'b0;
         rs_cnt      <= 8'h00;
      end else if (accept && legal) begin
         if (skip) begin
            rs_cnt <= rs_cnt + 8'd1;
         end else begin
            last_status <= status_new;
            ls_valid    <= 1'b1;
            rs_cnt      <= 8'h00;
         end
      end
   end
`else
   logic unused_rs;

   assign skip      = 1'b0;
   assign unused_rs = ^RS_LIM;
`endif

   always_ff @(posedge reg_clk) begin
      if (!reset_reg_n) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         err_q   <= accept && !legal;
      end
   end

   always_ff @(posedge reg_clk) begin
      if (!reset_reg_n) begin
         status_q <= 8'h00;
         d1_q     <= 7'h00;
         d2_q     <= 7'h00;
         prg_q    <= 1'b0;
      end else if (accept && legal) begin
         status_q <= status_new;
         d1_q     <= req_d1;
         d2_q     <= req_d2;
         prg_q    <= (req_type == 3'd3);
      end
   end

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      unique case (state_q)
         IDLE: begin
            if (accept && legal) begin
               state_d = skip ? DATA1 : STATUS;
            end
         end
         STATUS: begin
            tx_valid = 1'b1;
            tx_byte  = status_q;
            if (tx_ready) begin
               state_d = DATA1;
            end
         end
         DATA1: begin
            tx_valid = 1'b1;
            tx_byte  = {1'b0, d1_q};
            if (tx_ready) begin
               done_d  = prg_q;
               state_d = prg_q ? IDLE : DATA2;
            end
         end
         DATA2: begin
            tx_valid = 1'b1;
            tx_byte  = {1'b0, d2_q};
            if (tx_ready) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_midi_msg_tx.sv
// tb_midi_msg_tx: directed and random checks of midi_msg_tx
// against a message-level reference model.

module tb_midi_msg_tx;

   localparam int RS = 2;

   logic       reg_clk;
   logic       reset_reg_n;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_type;
   logic [3:0] req_ch;
   logic [6:0] req_d1;
   logic [6:0] req_d2;
   logic [7:0] tx_byte;
   logic       tx_valid;
   logic       tx_ready;
   logic       msg_done;
   logic       req_err;

   int nvec = 0;
   int nerr = 0;

   int rmode_g = 0;
   int pi = 0;
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];

   int         nib_tab [5] = '{8, 9, 11, 12, 14};
   bit         ms_valid = 1'b0;
   logic [7:0] ms_last = 8'h00;
   int         ms_cnt = 0;

   midi_msg_tx #(.RS_REFRESH(RS)) dut (
      .reg_clk    (reg_clk),
      .reset_reg_n(reset_reg_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_type   (req_type),
      .req_ch     (req_ch),
      .req_d1     (req_d1),
      .req_d2     (req_d2),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .msg_done   (msg_done),
      .req_err    (req_err)
   );

   initial reg_clk = 1'b0;
   always #5 reg_clk = ~reg_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] want);
      nvec++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, want);
      end
   endtask

   // Expected byte list of one request, from the message table.
   function automatic void model(input int t, input int ch,
                                 input int d1, input int d2);
      logic [7:0] st;
      bit omit;
      exp_q.delete();
      if (t > 4) return;
      st = 8'((nib_tab[t] * 16) + ch);
      omit = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      if (ms_valid && st == ms_last && ms_cnt < RS) begin
         omit = 1'b1;
         ms_cnt++;
      end else begin
         ms_last = st;
         ms_valid = 1'b1;
         ms_cnt = 0;
      end
`endif
      if (!omit) exp_q.push_back(st);
      exp_q.push_back(8'(d1 % 128));
      if (t != 3) exp_q.push_back(8'(d2 % 128));
   endfunction

   // UART side: tx_ready pattern per mode.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge reg_clk);
         #1;
         case (rmode_g)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: begin
               tx_ready = pat[pi % 4];
               pi++;
            end
         endcase
      end
   end

   // Byte collector and stall-stability monitor.
   initial begin
      logic pv;
      logic pr;
      logic [7:0] pb;
      pv = 1'b0;
      pr = 1'b0;
      pb = 8'h00;
      forever begin
         @(negedge reg_clk);
         if (pv && !pr && reset_reg_n) begin
            check("stall_valid", 32'(tx_valid), 32'd1);
            check("stall_byte", 32'(tx_byte), 32'(pb));
         end
         pv = tx_valid;
         pr = tx_ready;
         pb = tx_byte;
         if (tx_valid && tx_ready) got_q.push_back(tx_byte);
      end
   end

   task automatic send(input int t, input int ch,
                       input int d1, input int d2,
                       input int rmode, input bit tchk,
                       input bit poke);
      int n;
      bit done;
      rmode_g = rmode;
      pi = 0;
      model(t, ch, d1, d2);
      @(negedge reg_clk);
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge reg_clk);
         n++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
      got_q.delete();
      req_type = 3'(t);
      req_ch = 4'(ch);
      req_d1 = 7'(d1);
      req_d2 = 7'(d2);
      req_valid = 1'b1;
      @(posedge reg_clk);
      #1;
      req_valid = 1'b0;
      if (t > 4) begin
         @(negedge reg_clk);
         check("err_pulse", 32'(req_err), 32'd1);
         check("err_txv", 32'(tx_valid), 32'd0);
         @(negedge reg_clk);
         check("err_clear", 32'(req_err), 32'd0);
         check("err_txv2", 32'(tx_valid), 32'd0);
         check("err_ready", 32'(req_ready), 32'd1);
         return;
      end
      done = 1'b0;
      n = 0;
      while (!done && n < 300) begin
         @(negedge reg_clk);
         n++;
         if (n == 1) begin
            check("first_valid", 32'(tx_valid), 32'd1);
            check("first_byte", 32'(tx_byte), 32'(exp_q[0]));
         end
         if (poke && n == 2) begin
            req_type = 3'd1;
            req_ch = 4'd5;
            req_d1 = 7'h11;
            req_d2 = 7'h22;
            req_valid = 1'b1;
         end
         if (poke && n == 4) req_valid = 1'b0;
         if (msg_done) done = 1'b1;
      end
      req_valid = 1'b0;
      check("msg_done_seen", 32'(done), 32'd1);
      if (tchk) check("latency", 32'(n), 32'(exp_q.size() + 1));
      check("txv_at_done", 32'(tx_valid), 32'd0);
      check("ready_at_done", 32'(req_ready), 32'd1);
      check("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())
            check("byte", 32'(got_q[i]), 32'(exp_q[i]));
      end
      @(negedge reg_clk);
      check("done_pulse", 32'(msg_done), 32'd0);
      check("idle_txv", 32'(tx_valid), 32'd0);
   endtask

   initial begin
      int r;
      int t;
      int md;
      reset_reg_n = 1'b0;
      req_valid = 1'b0;
      req_type = 3'd0;
      req_ch = 4'd0;
      req_d1 = 7'd0;
      req_d2 = 7'd0;
      repeat (3) @(negedge reg_clk);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_txv", 32'(tx_valid), 32'd0);
      check("rst_byte", 32'(tx_byte), 32'd0);
      check("rst_done", 32'(msg_done), 32'd0);
      check("rst_err", 32'(req_err), 32'd0);
      @(posedge reg_clk);
      #1;
      reset_reg_n = 1'b1;
      @(negedge reg_clk);
      check("rel_ready", 32'(req_ready), 32'd1);

      send(1, 3, 'h3C, 'h64, 0, 1'b1, 1'b0);
      send(3, 0, 'h05, 'h7F, 0, 1'b1, 1'b0);
      send(4, 15, 'h00, 'h40, 2, 1'b0, 1'b1);
      send(6, 2, 'h12, 'h34, 0, 1'b0, 1'b0);
      send(0, 1, 'h40, 'h00, 0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         send(1, 0, 'h3C + i, 'h50, 0, 1'b1, 1'b0);
      send(1, 1, 'h3C, 'h50, 0, 1'b1, 1'b0);

      // Abandon a note_on after its status byte.
      rmode_g = 0;
      @(negedge reg_clk);
      model(1, 2, 'h30, 'h31);
      req_type = 3'd1;
      req_ch = 4'd2;
      req_d1 = 7'h30;
      req_d2 = 7'h31;
      req_valid = 1'b1;
      @(posedge reg_clk);
      #1;
      req_valid = 1'b0;
      @(negedge reg_clk);
      @(negedge reg_clk);
      reset_reg_n = 1'b0;
      @(negedge reg_clk);
      check("abort_txv", 32'(tx_valid), 32'd0);
      check("abort_byte", 32'(tx_byte), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd0);
      check("abort_done", 32'(msg_done), 32'd0);
      ms_valid = 1'b0;
      ms_cnt = 0;
      @(posedge reg_clk);
      #1;
      reset_reg_n = 1'b1;
      @(negedge reg_clk);
      check("abort_rel_ready", 32'(req_ready), 32'd1);
      send(1, 2, 'h30, 'h31, 0, 1'b1, 1'b0);
      check("resend_status", 32'(got_q.size()), 32'd3);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         t = (r > 7) ? 1 : r;
         md = int'($urandom_range(0, 1));
         send(t, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)),
              md, (md == 0), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
